// File: rtl/rom_arbiter.sv
// Round-robin two-port arbiter sharing one combinational ROM; registered address and response.
// Accept at T, rsp valid from T+2; response held until the owner's rsp ready, no new accept meanwhile.
module rom_arbiter #(
   parameter int data_width = 16,
   parameter int addr_width = 8,
   parameter int rom_depth  = 2**addr_width
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req0_valid_i,
   input  logic [addr_width-1:0] req0_addr_i,
   output logic                  req0_ready_o,
   input  logic                  req1_valid_i,
   input  logic [addr_width-1:0] req1_addr_i,
   output logic                  req1_ready_o,
   output logic                  rsp0_valid_o,
   input  logic                  rsp0_ready_i,
   output logic [data_width-1:0] rsp0_data_o,
   output logic                  rsp0_error_o,
   output logic                  rsp1_valid_o,
   input  logic                  rsp1_ready_i,
   output logic [data_width-1:0] rsp1_data_o,
   output logic                  rsp1_error_o,
   output logic [addr_width-1:0] rom_addr_o,
   input  logic [data_width-1:0] rom_data_i,
   input  logic                  rom_error_i
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]            state;
   logic                  last_grant;
   logic                  owner;
   logic                  oor;
   logic                  winner;
   logic                  accept;
   logic                  rsp_accept;
   logic [addr_width-1:0] win_addr;
   logic [data_width-1:0] rsp_data;
   logic                  rsp_error;

   // On a tie the port that was not granted last wins.
   always_comb begin
      winner = 1'b0;
      if (req0_valid_i && req1_valid_i) begin
         winner = ~last_grant;
      end else if (req1_valid_i) begin
         winner = 1'b1;
      end
   end

   assign req0_ready_o = (state == IDLE) && req0_valid_i && !winner;
   assign req1_ready_o = (state == IDLE) && req1_valid_i && winner;
   assign accept       = req0_ready_o || req1_ready_o;
   assign win_addr     = winner ? req1_addr_i : req0_addr_i;
   assign rsp_accept   = owner ? rsp1_ready_i : rsp0_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         oor        <= 1'b0;
         rom_addr_o <= '0;
         rsp_data   <= '0;
         rsp_error  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner      <= winner;
                  last_grant <= winner;
                  rom_addr_o <= win_addr;
                  oor        <= (32'(win_addr) >= 32'(rom_depth));
                  state      <= READ;
               end
            end
            READ: begin
               // ROM data is undefined on error, so never let it through.
               if (oor || rom_error_i) begin
                  rsp_data  <= '0;
                  rsp_error <= 1'b1;
               end else begin
                  rsp_data  <= rom_data_i;
                  rsp_error <= 1'b0;
               end
               state <= RESP;
            end
            RESP: begin
               if (rsp_accept) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rsp0_valid_o = (state == RESP) && !owner;
   assign rsp1_valid_o = (state == RESP) && owner;
   assign rsp0_data_o  = rsp_data;
   assign rsp1_data_o  = rsp_data;
   assign rsp0_error_o = rsp_error;
   assign rsp1_error_o = rsp_error;
endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized scoreboard bench for rom_arbiter with a transaction-level reference model
// and directed latency, tie, backpressure, error and asynchronous-reset scenarios.
module tb_rom_arbiter;
   localparam int DEPTH = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0]  req0_addr = '0, req1_addr = '0;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [15:0] rsp0_data, rsp1_data;
   logic        rsp0_error, rsp1_error;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        rom_error;
   logic        err_force = 1'b0;
   logic        rdy_rand = 1'b0, fix0 = 1'b1, fix1 = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last = 1;

   typedef struct {
      int          port;
      logic [7:0]  addr;
      logic [15:0] data;
      logic        err;
      int          acc;
   } exp_t;
   exp_t q[$];
   int   grants[$];

   always #5 clk = ~clk;

   rom_arbiter #(.data_width(16), .addr_width(8), .rom_depth(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(req0_valid), .req0_addr_i(req0_addr), .req0_ready_o(req0_ready),
      .req1_valid_i(req1_valid), .req1_addr_i(req1_addr), .req1_ready_o(req1_ready),
      .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
      .rsp0_data_o(rsp0_data), .rsp0_error_o(rsp0_error),
      .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
      .rsp1_data_o(rsp1_data), .rsp1_error_o(rsp1_error),
      .rom_addr_o(rom_addr), .rom_data_i(rom_data), .rom_error_i(rom_error)
   );

   function automatic logic [15:0] rom_word(input logic [7:0] a);
      if (a == 8'h05) return 16'hBEEF;
      return {a, ~a} ^ 16'h3C5A;
   endfunction

   // Behavioural ROM: word 0x77 is a faulty location, error data is garbage.
   assign rom_error = err_force || (rom_addr == 8'h77);
   assign rom_data  = rom_error ? 16'hDEAD : rom_word(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   function automatic exp_t model(input int p, input logic [7:0] a, input logic f, input int t);
      exp_t e;
      e.port = p;
      e.addr = a;
      e.err  = (int'(a) >= DEPTH) || (a == 8'h77) || f;
      e.data = e.err ? 16'h0000 : rom_word(a);
      e.acc  = t;
      return e;
   endfunction

   // Monitor / scoreboard: one outstanding access at a time, checked every cycle.
   always @(negedge clk) begin
      logic e0, e1, ev0, ev1, busy;
      if (rst_n) begin
         cyc++;
         busy = (q.size() != 0);
         e0 = !busy && req0_valid && (!req1_valid || last == 1);
         e1 = !busy && req1_valid && (!req0_valid || last == 0);
         chk("req_ready", {30'd0, req1_ready, req0_ready}, {30'd0, e1, e0});
         ev0 = 1'b0;
         ev1 = 1'b0;
         if (busy) begin
            if (cyc == q[0].acc + 1) chk("rom_addr", rom_addr, q[0].addr);
            ev0 = (q[0].port == 0) && (cyc >= q[0].acc + 2);
            ev1 = (q[0].port == 1) && (cyc >= q[0].acc + 2);
         end
         chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, {30'd0, ev1, ev0});
         if (ev0 || ev1) begin
            chk("rsp0_data", rsp0_data, q[0].data);
            chk("rsp1_data", rsp1_data, q[0].data);
            chk("rsp0_error", rsp0_error, q[0].err);
            chk("rsp1_error", rsp1_error, q[0].err);
            if ((ev0 && rsp0_valid && rsp0_ready) || (ev1 && rsp1_valid && rsp1_ready))
               void'(q.pop_front());
         end
         if (!busy && req0_ready && e0) begin
            q.push_back(model(0, req0_addr, err_force, cyc));
            grants.push_back(0);
            last = 0;
         end else if (!busy && req1_ready && e1) begin
            q.push_back(model(1, req1_addr, err_force, cyc));
            grants.push_back(1);
            last = 1;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) begin
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
         end else begin
            rsp0_ready = fix0;
            rsp1_ready = fix1;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic issue(input int p, input logic [7:0] a);
      bit got = 1'b0;
      if (p == 0) begin req0_valid = 1'b1; req0_addr = a; end
      else        begin req1_valid = 1'b1; req1_addr = a; end
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk);
         got = (p == 0) ? req0_ready : req1_ready;
      end
      if (!got) timeout("issue_handshake");
      @(posedge clk);
      #1;
      if (p == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         done = (q.size() == 0);
      end
      if (!done) timeout("drain");
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_out();
      chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("rst_rsp0_data", rsp0_data, 32'd0);
      chk("rst_rsp1_data", rsp1_data, 32'd0);
      chk("rst_rsp_error", {30'd0, rsp1_error, rsp0_error}, 32'd0);
      chk("rst_rom_addr", rom_addr, 32'd0);
      chk("rst_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
   endtask

   // Entered a couple of time units after a clock edge: reset lands mid-cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      last = 1;
      #1;
      chk_reset_out();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int held;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_out();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single fetch of ROM[5].
      issue(0, 8'h05);
      drain();

      // Continuous tie after reset alternates starting with port 0.
      #1 do_reset();
      grants.delete();
      fork
         begin repeat (4) issue(0, 8'h01); end
         begin repeat (4) issue(1, 8'h02); end
      join
      drain();
      chk("tie_count", grants.size(), 8);
      for (int i = 0; i < grants.size(); i++) chk("tie_order", grants[i], i % 2);

      // Port 1 response stalled for four cycles while port 0 waits.
      fix1 = 1'b0;
      issue(1, 8'h02);
      fork
         issue(0, 8'h01);
      join_none
      held = 0;
      for (int n = 0; n < 20 && !rsp1_valid; n++) @(negedge clk);
      if (!rsp1_valid) timeout("rsp1_wait");
      held = 1;
      repeat (3) begin
         @(negedge clk);
         if (rsp1_valid && !rsp1_ready) held++;
      end
      chk("rsp1_held", held, 4);
      fix1 = 1'b1;
      wait fork;
      drain();

      // Out-of-range address and forced ROM error.
      issue(0, 8'hC8);
      drain();
      err_force = 1'b1;
      issue(0, 8'h10);
      drain();
      err_force = 1'b0;

      // Reset during READ.
      issue(0, 8'h20);
      #1 do_reset();
      repeat (3) @(negedge clk);
      chk("no_rsp_after_rst_read", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(posedge clk);
      #1;

      // Reset during RESP, then the first tie goes to port 0.
      fix0 = 1'b0;
      issue(0, 8'h21);
      @(posedge clk);
      #1;
      chk("resp_before_rst", rsp0_valid, 32'd1);
      #1 do_reset();
      fix0 = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_rsp_after_rst_resp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(posedge clk);
      #1;
      grants.delete();
      fork
         issue(0, 8'h03);
         issue(1, 8'h04);
      join
      drain();
      chk("tie_after_reset", (grants.size() > 0) ? grants[0] : -1, 0);

      // Random traffic with random response backpressure.
      rdy_rand = 1'b1;
      fork
         begin
            repeat (80) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               issue(0, 8'($urandom_range(0, 255)));
            end
         end
         begin
            #1;
            repeat (80) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               issue(1, 8'($urandom_range(0, 255)));
            end
         end
      join
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and sequencer that shares one combinational instruction/constant ROM between two requesters: port 0 is instruction fetch and port 1 is data load. The arbiter accepts requests over valid/ready handshakes and grants them round-robin. It drives the ROM address from a register, then captures ROM data and error into a response register. Responses are held until the owning requester accepts them. It sits between the core's fetch/load units and the ROM macro, and it converts the ROM's X-on-error behaviour into defined data plus an error flag.

## Interface
- data_width, 16, ROM word width
- addr_width, 8, ROM address width
- rom_depth, 2**addr_width, number of valid ROM words; addresses >= rom_depth are out of range
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req0_valid_i / req1_valid_i  in  1  request valid, port 0 / port 1
- req0_addr_i / req1_addr_i  in  addr_width  request word address
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle
- rsp0_valid_o / rsp1_valid_o  out  1  response valid
- rsp0_ready_i / rsp1_ready_i  in  1  response accepted by requester
- rsp0_data_o / rsp1_data_o  out  data_width  response data
- rsp0_error_o / rsp1_error_o  out  1  response error flag
- rom_addr_o  out  addr_width  address to ROM (registered)
- rom_data_i  in  data_width  ROM read data (combinational from rom_addr_o)
- rom_error_i  in  1  ROM error flag (combinational)

## Operation
- FSM states:
  - IDLE: accept a request.
  - READ: ROM access in flight.
  - RESP: response held.
- IDLE:
  - Grant logic picks the winner among asserted req valids.
  - Only one requester valid: it wins.
  - Both valid: the port not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
  - reqN_ready_o = (state==IDLE) && reqN_valid_i && winner==N. At most one ready is high per cycle.
  - On handshake:
    - owner <= N
    - rom_addr_o <= reqN_addr_i
    - oor <= (reqN_addr_i >= rom_depth)
    - last_grant <= N
    - go to READ
- READ:
  - If oor: capture data = 0, error = 1.
  - Else: capture data = rom_data_i, error = rom_error_i.
  - If error: data is forced to 0. Never propagate X.
  - Go to RESP.
- RESP:
  - rsp{owner}_valid_o = 1. The other port's rsp valid stays 0.
  - Both ports' rsp data/error outputs carry the captured register. Only the owner's valid qualifies it.
  - On rsp{owner}_ready_i: go to IDLE. A new request is not accepted in the same cycle.
- Requester rules:
  - Hold valid and addr stable until ready.
  - Data/error outputs are stable while valid is high and ready is low.
- rom_addr_o holds its last value outside READ.
- Reset asserted mid-operation:
  - State goes to IDLE.
  - Any in-flight or held response is dropped, and no rsp valid is issued for it.
  - A requester must reissue.

## Timing
- Reset values:
  - state IDLE; last_grant 1; owner 0
  - rom_addr_o 0
  - all rsp valid 0; rsp data 0; rsp error 0
  - req ready follows the IDLE equation, so it is 0 unless a valid is present.
- Latency: accept in cycle T, READ in T+1, rsp valid high from T+2.
- rsp valid stays high until the cycle ready is sampled high, inclusive.
- Peak throughput: one access per 3 cycles with rsp ready tied high.
- No combinational path from rom_data_i to any output. Outputs are registered, except req ready (decoded from state and valids).

## Test plan
- Reset, then port 0 reads addr 0x05 (ROM[5]=0xBEEF), rsp0_ready high:
  - req0_ready at T
  - rom_addr_o=0x05 at T+1
  - rsp0_valid, data 0xBEEF, error 0 at T+2
  - rsp1_valid stays 0
- Both ports valid continuously, port 0 addr 0x01, port 1 addr 0x02:
  - Grants alternate 0,1,0,1 starting with port 0.
  - Each response returns the matching ROM word to the matching port.
- Port 1 response with rsp1_ready low for 4 cycles:
  - rsp1_valid held 4 cycles with data constant.
  - A port 0 request pending meanwhile sees req0_ready 0 until 1 cycle after rsp1 accept.
- rom_depth=200, port 0 reads 0xC8:
  - rsp0 data 0x0000, error 1.
  - Separately, rom_error_i forced 1 on an in-range read also gives data 0, error 1.
- Assert rst_ni low asynchronously during READ and during RESP:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - No rsp valid after release until a new handshake.
  - The first tie after reset is granted to port 0.
